// File: rtl/soft_block_placer.sv
// soft_block_placer: builds the start-of-round tile map.
// Seeds the external LFSR from a free-running counter, lets it mix for WARMUP
// cycles, then walks the grid row-major writing one classified tile per clock.
module soft_block_placer #(
  parameter int MAP_W   = 15,
  parameter int MAP_H   = 11,
  parameter int ADDR_W  = 8,
  parameter int DENSITY = 160,
  parameter int WARMUP  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       lfsr_in,
  output logic              lfsr_w_en,
  output logic [15:0]       lfsr_w_in,
  output logic              tile_we,
  output logic [ADDR_W-1:0] tile_addr,
  output logic [1:0]        tile_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        block_count
);

  localparam int ROW_W  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int COL_W  = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int WARM_W = $clog2(WARMUP + 1);
  localparam logic [8:0] DENS = 9'(DENSITY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WARM,
    S_FILL,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [15:0]        seed_ctr;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [WARM_W-1:0]  warm_ctr;
  logic               last_tile;
  logic               lfsr_hi_unused;

  // Only the low byte of the random word decides soft-block placement.
  assign lfsr_hi_unused = ^lfsr_in[15:8];

  assign last_tile = (row == ROW_W'(MAP_H - 1)) && (col == COL_W'(MAP_W - 1));

  // Tile classification: pillar grid first, then the spawn-corner safe zones,
  // then a random soft block with probability DENSITY/256.
  function automatic logic [1:0] classify(input logic [ROW_W-1:0] r,
                                          input logic [COL_W-1:0] c,
                                          input logic [7:0]       rnd);
    logic end_row, side_row, outer_col, inner_col;
    end_row   = (r == ROW_W'(0)) || (r == ROW_W'(MAP_H - 1));
    side_row  = (r == ROW_W'(1)) || (r == ROW_W'(MAP_H - 2));
    outer_col = (c == COL_W'(0)) || (c == COL_W'(MAP_W - 1));
    inner_col = (c == COL_W'(1)) || (c == COL_W'(MAP_W - 2));
    if (r[0] && c[0])
      return 2'd1;
    if ((end_row && (outer_col || inner_col)) || (side_row && outer_col))
      return 2'd0;
    if ({1'b0, rnd} < DENS)
      return 2'd2;
    return 2'd0;
  endfunction

  // Free-running entropy counter; the start time picks the round's seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seed_ctr <= 16'h0001;
    else     seed_ctr <= seed_ctr + 16'd1;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and combinational outputs; tile_we falls with the async reset.
  always_comb begin
    state_n   = state;
    lfsr_w_en = 1'b0;
    lfsr_w_in = 16'h0000;
    tile_we   = 1'b0;
    tile_addr = '0;
    tile_data = 2'd0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_SEED;
      end
      S_SEED: begin
        busy      = 1'b1;
        lfsr_w_en = 1'b1;
        lfsr_w_in = seed_ctr | 16'h0001;
        state_n   = S_WARM;
      end
      S_WARM: begin
        busy = 1'b1;
        if (warm_ctr == WARM_W'(WARMUP - 1)) state_n = S_FILL;
      end
      S_FILL: begin
        busy      = 1'b1;
        tile_we   = 1'b1;
        tile_addr = ADDR_W'(row) * ADDR_W'(MAP_W) + ADDR_W'(col);
        tile_data = classify(row, col, lfsr_in[7:0]);
        if (last_tile) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Grid walker, warm-up counter and soft-block tally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row         <= '0;
      col         <= '0;
      warm_ctr    <= '0;
      block_count <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            row         <= '0;
            col         <= '0;
            block_count <= 8'd0;
          end
        end
        S_SEED: warm_ctr <= '0;
        S_WARM: warm_ctr <= warm_ctr + WARM_W'(1);
        S_FILL: begin
          if (tile_data == 2'd2) block_count <= block_count + 8'd1;
          if (!last_tile) begin
            if (col == COL_W'(MAP_W - 1)) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Completion pulse, registered so it lands the cycle after the DONE state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= 1'b0;
    else     done <= (state == S_DONE);
  end

endmodule

// File: tb/tb_soft_block_placer.sv
// Scoreboard bench for soft_block_placer: three instances (DENSITY 160, 0, 256)
// share one LFSR stand-in; stimulus pushes expected seeds, writes and done
// events, a negedge monitor pops and compares them.
module tb_soft_block_placer;

  localparam int W  = 15;
  localparam int H  = 11;
  localparam int AW = 8;
  localparam int WU = 16;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] lfsr_q;
  int cyc;
  int n_cmp = 0;
  int n_err = 0;

  logic          w_en_a, we_a, busy_a, done_a;
  logic [15:0]   w_in_a;
  logic [AW-1:0] addr_a;
  logic [1:0]    data_a;
  logic [7:0]    bc_a;
  logic          w_en_z, we_z, busy_z, done_z;
  logic [15:0]   w_in_z;
  logic [AW-1:0] addr_z;
  logic [1:0]    data_z;
  logic [7:0]    bc_z;
  logic          w_en_f, we_f, busy_f, done_f;
  logic [15:0]   w_in_f;
  logic [AW-1:0] addr_f;
  logic [1:0]    data_f;
  logic [7:0]    bc_f;

  soft_block_placer #(.MAP_W(W), .MAP_H(H), .ADDR_W(AW), .DENSITY(160), .WARMUP(WU)) u_a (
    .clk(clk), .rst(rst), .start(start), .lfsr_in(lfsr_q),
    .lfsr_w_en(w_en_a), .lfsr_w_in(w_in_a), .tile_we(we_a), .tile_addr(addr_a),
    .tile_data(data_a), .busy(busy_a), .done(done_a), .block_count(bc_a));

  soft_block_placer #(.MAP_W(W), .MAP_H(H), .ADDR_W(AW), .DENSITY(0), .WARMUP(WU)) u_z (
    .clk(clk), .rst(rst), .start(start), .lfsr_in(lfsr_q),
    .lfsr_w_en(w_en_z), .lfsr_w_in(w_in_z), .tile_we(we_z), .tile_addr(addr_z),
    .tile_data(data_z), .busy(busy_z), .done(done_z), .block_count(bc_z));

  soft_block_placer #(.MAP_W(W), .MAP_H(H), .ADDR_W(AW), .DENSITY(256), .WARMUP(WU)) u_f (
    .clk(clk), .rst(rst), .start(start), .lfsr_in(lfsr_q),
    .lfsr_w_en(w_en_f), .lfsr_w_in(w_in_f), .tile_we(we_f), .tile_addr(addr_f),
    .tile_data(data_f), .busy(busy_f), .done(done_f), .block_count(bc_f));

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  // LFSR stand-in, loaded by the main instance.
  always @(posedge clk or posedge rst) begin
    if (rst)         lfsr_q <= 16'hACE1;
    else if (w_en_a) lfsr_q <= w_in_a;
    else             lfsr_q <= lfsr_step(lfsr_q);
  end

  // Clock edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int safe_r[12] = '{0, 0, 1, 0, 0, 1, H-1, H-1, H-2, H-1, H-1, H-2};
  int safe_c[12] = '{0, 1, 0, W-1, W-2, W-1, 0, 1, 0, W-1, W-2, W-1};

  function automatic logic [1:0] ref_tile(input int r, input int c,
                                          input logic [7:0] rnd, input int dens);
    if ((r % 2 == 1) && (c % 2 == 1)) return 2'd1;
    for (int i = 0; i < 12; i++)
      if (safe_r[i] == r && safe_c[i] == c) return 2'd0;
    if (int'(rnd) < dens) return 2'd2;
    return 2'd0;
  endfunction

  typedef struct { int addr; logic [1:0] a; logic [1:0] z; logic [1:0] f; } wr_t;
  typedef struct { int cyc; logic [15:0] seed; } seed_t;
  typedef struct { int cyc; int bc_a; int bc_z; int bc_f; } done_t;
  wr_t   wq[$];
  seed_t sq[$];
  done_t dq[$];

  logic [1:0] cur_map[N];
  logic [1:0] prev_map[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected response of a map whose SEED cycle is t; nwr limits the writes
  // for a map that will be cut short (no done expected then).
  task automatic push_map(input int t, input int nwr);
    logic [15:0] q;
    seed_t s;
    wr_t   w;
    done_t d;
    s.cyc  = t;
    s.seed = 16'(t + 1) | 16'h0001;
    sq.push_back(s);
    q = s.seed;
    for (int i = 0; i < WU; i++) q = lfsr_step(q);
    d.cyc = t + 2 + WU + N;
    d.bc_a = 0; d.bc_z = 0; d.bc_f = 0;
    for (int k = 0; k < N; k++) begin
      w.addr = k;
      w.a = ref_tile(k / W, k % W, q[7:0], 160);
      w.z = ref_tile(k / W, k % W, q[7:0], 0);
      w.f = ref_tile(k / W, k % W, q[7:0], 256);
      if (w.a == 2'd2) d.bc_a++;
      if (w.z == 2'd2) d.bc_z++;
      if (w.f == 2'd2) d.bc_f++;
      if (k < nwr) wq.push_back(w);
      q = lfsr_step(q);
    end
    if (nwr >= N) dq.push_back(d);
  endtask

  // Called at a negedge: raise start for one cycle and predict the map.
  task automatic issue_start(output int t);
    start = 1'b1;
    t = cyc + 1;
    push_map(t, N);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      #1;
      i++;
    end while ((wq.size() + sq.size() + dq.size()) != 0 && i < limit);
    check("drain_left", wq.size() + sq.size() + dq.size(), 0);
    wq.delete();
    sq.delete();
    dq.delete();
  endtask

  // Monitor: pops expectations whenever the DUTs present an event.
  always @(negedge clk) begin
    if (w_en_a) begin
      if (sq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL seed_unexpected: got lfsr_w_en=1, expected no seed (cycle %0d)", cyc);
      end else begin
        seed_t e;
        e = sq.pop_front();
        check("seed_cycle", cyc, e.cyc);
        check("seed_value", w_in_a, e.seed);
        check("bc_cleared", bc_a, 0);
      end
    end
    check("we_lockstep", {we_z, we_f}, {we_a, we_a});
    if (we_a) begin
      if (wq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL write_unexpected: got write addr %0d, expected none (cycle %0d)", addr_a, cyc);
      end else begin
        wr_t e;
        e = wq.pop_front();
        check("addr", addr_a, e.addr);
        check("data_d160", data_a, e.a);
        check("data_d0", data_z, e.z);
        check("data_d256", data_f, e.f);
        check("busy_fill", busy_a, 1'b1);
        if (int'(addr_a) < N) cur_map[addr_a] = data_a;
      end
    end
    if (done_a || done_z || done_f) begin
      if (dq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL done_unexpected: got done=%b%b%b, expected 000 (cycle %0d)",
                 done_a, done_z, done_f, cyc);
      end else begin
        done_t e;
        e = dq.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("done_all", {done_a, done_z, done_f}, 3'b111);
        check("done_busy", busy_a, 1'b0);
        check("bc_d160", bc_a, e.bc_a);
        check("bc_d0", bc_z, e.bc_z);
        check("bc_d256", bc_f, e.bc_f);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish, expected completion by 1500000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, t2, ndiff;
    repeat (3) @(negedge clk);
    check("rst_w_en", w_en_a, 1'b0);
    check("rst_w_in", w_in_a, 16'h0000);
    check("rst_we", we_a, 1'b0);
    check("rst_addr", addr_a, 0);
    check("rst_data", data_a, 2'd0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_bc", bc_a, 8'd0);
    rst = 1'b0;

    // Map with starts in WARM, FILL and DONE that must all be ignored.
    repeat (2) @(negedge clk);
    issue_start(t);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc != t + 60) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc != t + 1 + WU + N) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(60);

    // Start held high: back-to-back maps, second SEED one cycle after done.
    @(negedge clk);
    start = 1'b1;
    t = cyc + 1;
    push_map(t, N);
    t2 = t + 3 + WU + N;
    push_map(t2, N);
    while (cyc != t2) @(negedge clk);
    start = 1'b0;
    wait_drain(400);

    // Reset on the 50th FILL cycle: 49 writes seen, no done.
    @(negedge clk);
    start = 1'b1;
    t = cyc + 1;
    push_map(t, 49);
    @(negedge clk);
    start = 1'b0;
    while (cyc != t + WU + 49) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_we", we_a, 1'b0);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_done", done_a, 1'b0);
    check("midrst_writes_left", wq.size(), 0);
    sq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_done", done_a, 1'b0);
    issue_start(t);
    wait_drain(250);

    // Seed counter wraps to zero in the SEED cycle: loaded seed must be 1.
    @(negedge clk);
    while ((cyc & 16'hFFFF) != 16'hFFFE) @(negedge clk);
    issue_start(t);
    wait_drain(250);
    for (int i = 0; i < N; i++) prev_map[i] = cur_map[i];

    // A later start gives a different seed and a different soft map.
    repeat (7) @(negedge clk);
    issue_start(t);
    wait_drain(250);
    ndiff = 0;
    for (int i = 0; i < N; i++) if (cur_map[i] !== prev_map[i]) ndiff++;
    check("maps_differ", (ndiff != 0), 1'b1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
